// File: rtl/embedded_soc_pio_in_capture.sv
`default_nettype none
// ============================================================================
// Module   : embedded_soc_pio_in_capture
// Purpose  : Avalon-MM input PIO with synchronizer, sticky edge capture
//            (write-1-to-clear), per-bit interrupt mask and level irq.
// Revision : 1.0 - initial release
// ============================================================================
module embedded_soc_pio_in_capture #(
    parameter int WIDTH       = 32,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Capture stays disabled until every synchronizer stage and prev hold real samples.
    localparam int c_ARM_COUNT = SYNC_STAGES + 1;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [2:0]       r_warm;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic             w_armed;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_wr    = chipselect & ~write_n;
    assign w_armed = (r_warm == 3'(c_ARM_COUNT));
    assign w_clr   = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign w_edge = w_sync & ~r_prev;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign w_edge = ~w_sync & r_prev;
        end else begin : g_any
            assign w_edge = w_sync ^ r_prev;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
            r_warm <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync;
            if (!w_armed) begin
                r_warm <= r_warm + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
            r_cap  <= '0;
        end else begin
            if (w_wr && address == 2'd2) begin
                r_mask <= writedata[WIDTH-1:0];
            end
            // A new edge overrides a same-cycle clear of that bit.
            r_cap <= (r_cap & ~w_clr) | (w_armed ? w_edge : '0);
        end
    end

    assign irq = |(r_cap & r_mask);

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = w_sync;
            2'd2:    readdata[WIDTH-1:0] = r_mask;
            2'd3:    readdata[WIDTH-1:0] = r_cap;
            default: readdata = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/embedded_soc_pio_in_capture.md
# embedded_soc_pio_in_capture

Avalon-MM slave input PIO: the read-side counterpart of the SoC's output PIO. Samples a WIDTH-bit external input bus through a synchronizer, exposes the synchronized level to the processor, latches qualifying edges per bit in a sticky edge-capture register, and raises a level interrupt for any captured edge whose mask bit is set. Sits on the system interconnect next to the output PIOs and connects to the interrupt controller.

## Interface
Parameters:
- WIDTH, 32, number of input bits (1..32).
- EDGE_TYPE, 0, capture condition: 0 rising, 1 falling, 2 any edge.
- SYNC_STAGES, 2, synchronizer flop count (2..4).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  2  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  read data, zero-extended above WIDTH.
- irq  output  1  level interrupt, active high.

## Operation
- Register map: 0 DATA (RO, synchronized in_port), 1 reserved (reads 0, writes ignored), 2 IRQMASK (RW, WIDTH bits), 3 EDGECAPTURE (read; write-1-to-clear).
- Write occurs when chipselect=1 and write_n=0. Writes to address 0 are ignored.
- Synchronizer: SYNC_STAGES flops per bit; last stage = sync. One further register prev holds last cycle's sync.
- Edge vector: rising = sync & ~prev; falling = ~sync & prev; any = sync ^ prev; selected by EDGE_TYPE.
- EDGECAPTURE[i] sets on edge[i] (when armed) and holds until cleared by writing 1 to bit i at address 3. Writing 0 leaves the bit unchanged.
- Simultaneous edge and clear on the same bit in the same cycle: set wins (bit remains 1).
- Arming: a saturating warm-up counter starts at 0 on reset; edge capture is disabled until the synchronizer and prev hold valid samples, i.e. no EDGECAPTURE bit can set on the first SYNC_STAGES+1 rising clk edges after reset_n deasserts. An input held high through reset therefore produces no rising-edge capture.
- irq = OR over bits of (EDGECAPTURE & IRQMASK). Clearing the mask deasserts irq without clearing captures.
- readdata: combinational decode of address, zero-extended; bits above WIDTH always 0; chipselect does not gate readdata.

## Timing
- Reset (asynchronous): synchronizer stages, prev, IRQMASK, EDGECAPTURE and warm-up counter all 0; readdata reflects 0 for any address; irq = 0.
- Read latency 0: readdata is valid in the same cycle as address.
- in_port change settled before posedge k: DATA reflects it after posedge k+SYNC_STAGES-1; EDGECAPTURE bit sets at posedge k+SYNC_STAGES; irq asserts combinationally in that same cycle if masked in.
- Pulses shorter than one clk period may be missed; this is not an error condition.
- IRQMASK write at posedge n: irq reflects the new mask after posedge n.
- EDGECAPTURE clear at posedge n: bit reads 0 after posedge n unless a new edge coincided.
- reset_n assertion mid-operation: all state clears immediately and warm-up restarts on deassertion.

## Test plan
- Reset/idle: hold reset_n=0 with in_port=0xFFFFFFFF, release -> no EDGECAPTURE bits for entire run, DATA reads 0xFFFFFFFF after SYNC_STAGES edges, irq=0.
- Rising capture (EDGE_TYPE=0): IRQMASK=0x1, in_port bit0 0->1 before posedge k -> EDGECAPTURE=0x1 and irq=1 after posedge k+2; 1->0 transition -> no new capture.
- Write-1-to-clear: EDGECAPTURE=0x5, write 0x4 to address 3 -> reads 0x1; irq follows mask; write 0x0 -> unchanged.
- Set/clear collision: new edge on bit3 arrives the same cycle as a clear write of 0x8 -> bit3 still 1 afterwards.
- Mask gating: captures 0xF0, IRQMASK=0x0F -> irq=0; write IRQMASK=0x10 -> irq=1 after the next posedge; address 1 reads 0.
- EDGE_TYPE=2, WIDTH=8: toggle bit7 1->0->1 with clears between -> capture on each transition; readdata[31:8]=0 always.
